// File: rtl/computer_pkg.sv
// Shared constants for the 8-bit computer's output path: segment codes,
// display FSM state encodings and the BCD digit count.
package computer_pkg;

  localparam int unsigned BCD_DIGITS = 3;

  // Active-low segment codes, bit0 = seg a ... bit6 = seg g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_UPDATE  = 2'd2;

endpackage

// File: rtl/output_display_if.sv
// Load/status bundle between the computer's OUT register and the display block.
interface output_display_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_load;
  logic             busy;
  logic             done;
  logic [11:0]      bcd;

  modport master (output out_data, out_load, input busy, done, bcd);
  modport slave  (input out_data, out_load, output busy, done, bcd);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
module seg7_decoder
  import computer_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/output_display.sv
// Sequential double-dabble binary-to-BCD converter driving three seven-segment digits,
// with a one-deep pending buffer. Define OUTPUT_DISPLAY_BLANK_EN to blank leading zeros.
module output_display
  import computer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  output_display_if.slave     bus,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2
);

  localparam int unsigned ITER = WIDTH;
  localparam int unsigned SW   = WIDTH + 12;
  localparam int unsigned CNTW = (ITER > 1) ? $clog2(ITER) : 1;

`ifdef OUTPUT_DISPLAY_BLANK_EN
  localparam logic [6:0] HEX2_RST = SEG_BLANK;
  localparam logic [6:0] HEX1_RST = SEG_BLANK;
`else
  localparam logic [6:0] HEX2_RST = SEG_0;
  localparam logic [6:0] HEX1_RST = SEG_0;
`endif

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    sr_q, sr_d, sr_step;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [6:0]       hex0_q, hex1_q, hex2_q;
  logic [6:0]       hex0_d, hex1_d, hex2_d;
  logic [6:0]       seg_u, seg_t, seg_h, hex1_nx, hex2_nx;
  logic [11:0]      dig;

  assign dig = sr_q[SW-1:WIDTH];

  seg7_decoder u_dec_units    (.digit(dig[3:0]),  .seg(seg_u));
  seg7_decoder u_dec_tens     (.digit(dig[7:4]),  .seg(seg_t));
  seg7_decoder u_dec_hundreds (.digit(dig[11:8]), .seg(seg_h));

`ifdef OUTPUT_DISPLAY_BLANK_EN
  assign hex2_nx = (dig[11:8] == 4'd0) ? SEG_BLANK : seg_h;
  assign hex1_nx = (dig[11:4] == 8'd0) ? SEG_BLANK : seg_t;
`else
  assign hex2_nx = seg_h;
  assign hex1_nx = seg_t;
`endif

  // One double-dabble iteration: add 3 to any nibble >= 5, then shift left.
  always_comb begin
    logic [SW-1:0] adj;
    adj = sr_q;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (adj[WIDTH+4*k +: 4] >= 4'd5) adj[WIDTH+4*k +: 4] = adj[WIDTH+4*k +: 4] + 4'd3;
    end
    sr_step = adj << 1;
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bcd_d       = bcd_q;
    hex0_d      = hex0_q;
    hex1_d      = hex1_q;
    hex2_d      = hex2_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.out_load) begin
          sr_d    = {12'b0, bus.out_data};
          cnt_d   = '0;
          state_d = ST_CONVERT;
          busy_d  = 1'b1;
        end
      end
      ST_CONVERT: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(ITER - 1)) state_d = ST_UPDATE;
        if (bus.out_load) begin
          pend_d      = 1'b1;
          pend_data_d = bus.out_data;
        end
      end
      ST_UPDATE: begin
        bcd_d  = dig;
        hex0_d = seg_u;
        hex1_d = hex1_nx;
        hex2_d = hex2_nx;
        done_d = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (pend_q) begin
          // Pending value starts now; a load this cycle becomes the new pending one.
          sr_d    = {12'b0, pend_data_q};
          state_d = ST_CONVERT;
          busy_d  = 1'b1;
          pend_d  = bus.out_load;
          if (bus.out_load) pend_data_d = bus.out_data;
        end else if (bus.out_load) begin
          sr_d    = {12'b0, bus.out_data};
          state_d = ST_CONVERT;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bcd_q       <= 12'h000;
      hex0_q      <= SEG_0;
      hex1_q      <= HEX1_RST;
      hex2_q      <= HEX2_RST;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bcd_q       <= bcd_d;
      hex0_q      <= hex0_d;
      hex1_q      <= hex1_d;
      hex2_q      <= hex2_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign HEX0     = hex0_q;
  assign HEX1     = hex1_q;
  assign HEX2     = hex2_q;

endmodule

// File: tb/tb_output_display.sv
// Self-checking bench for output_display: timeline model of loads, pending buffer and
// display updates, compared every cycle, plus hand-computed literal checks.
module tb_output_display;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b0;
  logic [6:0] hex0, hex1, hex2;

  output_display_if #(.WIDTH(8)) bus ();

  output_display #(.WIDTH(8)) dut (
    .CLOCK_50(CLOCK_50),
    .rst_n   (rst_n),
    .bus     (bus),
    .HEX0    (hex0),
    .HEX1    (hex1),
    .HEX2    (hex2)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] hex_of(input logic [11:0] b, input int idx);
`ifdef OUTPUT_DISPLAY_BLANK_EN
    if (idx == 2 && b[11:8] == 4'd0) return 7'h7F;
    if (idx == 1 && b[11:4] == 8'd0) return 7'h7F;
`endif
    return seg_tab[b[4*idx +: 4]];
  endfunction

  // Model: a conversion started at edge S publishes its value at edge S+9.
  int          n = 0;
  bit          m_act = 0, m_pv = 0, m_busy = 0, m_done = 0;
  int          m_val = 0, m_end = 0, m_pval = 0;
  logic [11:0] m_bcd = 12'h000;

  task automatic m_start(input int v);
    m_act = 1;
    m_val = v;
    m_end = n + 9;
  endtask

  always @(posedge CLOCK_50 or negedge rst_n) begin
    bit ld;
    int d;
    if (!rst_n) begin
      m_act = 0; m_pv = 0; m_busy = 0; m_done = 0; m_bcd = 12'h000;
    end else begin
      ld = bus.out_load;
      d  = int'(bus.out_data);
      n++;
      m_done = 0;
      if (m_act && n == m_end) begin
        m_bcd  = to_bcd(m_val);
        m_done = 1;
        if (m_pv) begin
          m_start(m_pval);
          m_pv = ld;
          if (ld) m_pval = d;
        end else if (ld) m_start(d);
        else m_act = 0;
      end else if (m_act) begin
        if (ld) begin m_pv = 1; m_pval = d; end
      end else if (ld) m_start(d);
      m_busy = m_act;
    end
  end

  int busy_cnt = 0, done_cnt = 0;
  bit seen45 = 0;

  always @(negedge CLOCK_50) begin
    if (cmp_en) begin
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("bcd",  32'(bus.bcd),  32'(m_bcd));
      chk("hex0", 32'(hex0), 32'(hex_of(m_bcd, 0)));
      chk("hex1", 32'(hex1), 32'(hex_of(m_bcd, 1)));
      chk("hex2", 32'(hex2), 32'(hex_of(m_bcd, 2)));
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) done_cnt++;
      if (bus.bcd === 12'h045) seen45 = 1;
    end
  end

  task automatic load(input logic [7:0] v);
    @(negedge CLOCK_50);
    bus.out_load = 1'b1;
    bus.out_data = v;
    @(negedge CLOCK_50);
    bus.out_load = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLOCK_50);
      if (bus.done === 1'b1) begin got = 1; break; end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done within 30 cycles", name);
    end
  endtask

  task automatic chk_lit(input string name, input logic [11:0] b, input logic [6:0] h2,
                         input logic [6:0] h1, input logic [6:0] h0);
    chk({name, "_bcd"},  32'(bus.bcd), 32'(b));
    chk({name, "_hex2"}, 32'(hex2), 32'(h2));
    chk({name, "_hex1"}, 32'(hex1), 32'(h1));
    chk({name, "_hex0"}, 32'(hex0), 32'(h0));
  endtask

  logic [7:0]  bvals [5] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100};
  logic [11:0] bexp  [5] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100};

  initial begin
    bus.out_load = 1'b0;
    bus.out_data = '0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef OUTPUT_DISPLAY_BLANK_EN
    chk_lit("rst", 12'h000, 7'h7F, 7'h7F, 7'h40);
`else
    chk_lit("rst", 12'h000, 7'h40, 7'h40, 7'h40);
`endif

    // 255: nine busy cycles, single done pulse.
    busy_cnt = 0; done_cnt = 0;
    load(8'hFF);
    wait_done("ff");
    chk_lit("ff", 12'h255, 7'h24, 7'h12, 7'h12);
    repeat (4) @(negedge CLOCK_50);
    chk("ff_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("ff_done_pulses", 32'(done_cnt), 32'd1);

    // 123, then 45 and 7 while busy: 45 superseded, 7 follows with no gap.
    seen45 = 0;
    load(8'd123);
    load(8'd45);
    load(8'd7);
    wait_done("p123");
    chk_lit("p123", 12'h123, 7'h79, 7'h24, 7'h30);
    chk("p123_still_busy", 32'(bus.busy), 32'd1);
    wait_done("p7");
`ifdef OUTPUT_DISPLAY_BLANK_EN
    chk_lit("p7", 12'h007, 7'h7F, 7'h7F, 7'h78);
`else
    chk_lit("p7", 12'h007, 7'h40, 7'h40, 7'h78);
`endif
    repeat (12) @(negedge CLOCK_50);
    chk("never_45", 32'(seen45), 32'd0);

    // Reset in the middle of converting 200.
    load(8'd200);
    repeat (3) @(posedge CLOCK_50);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
`ifdef OUTPUT_DISPLAY_BLANK_EN
    chk_lit("mid_rst", 12'h000, 7'h7F, 7'h7F, 7'h40);
`else
    chk_lit("mid_rst", 12'h000, 7'h40, 7'h40, 7'h40);
`endif
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (14) @(negedge CLOCK_50);
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    chk("mid_rst_bcd", 32'(bus.bcd), 32'h000);

    // Leading-zero handling.
    load(8'd7);
    wait_done("d7");
`ifdef OUTPUT_DISPLAY_BLANK_EN
    chk_lit("d7", 12'h007, 7'h7F, 7'h7F, 7'h78);
`else
    chk_lit("d7", 12'h007, 7'h40, 7'h40, 7'h78);
`endif
    load(8'd40);
    wait_done("d40");
`ifdef OUTPUT_DISPLAY_BLANK_EN
    chk_lit("d40", 12'h040, 7'h7F, 7'h19, 7'h40);
`else
    chk_lit("d40", 12'h040, 7'h40, 7'h19, 7'h40);
`endif
    load(8'd100);
    wait_done("d100");
    chk_lit("d100", 12'h100, 7'h79, 7'h40, 7'h40);

    // Add-3 boundaries.
    for (int i = 0; i < 5; i++) begin
      load(bvals[i]);
      repeat (11) @(negedge CLOCK_50);
      chk($sformatf("bnd_%0d", bvals[i]), 32'(bus.bcd), 32'(bexp[i]));
    end

    repeat (3) @(negedge CLOCK_50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_display.md
Name: output_display

Overview:
- Downstream consumer of the 8-bit computer's output register.
- Takes the OUT-register value and its load strobe, then converts the binary value to BCD with a sequential double-dabble engine (one iteration per clock).
- Drives three active-low seven-segment digits (HEX2:HEX0 = hundreds:tens:units) on the DE2 board.
- A one-deep pending buffer absorbs OUT writes that arrive while a conversion is running.

Parameters:
- WIDTH, 8, binary input width; legal range 1..9 so the maximum value is ≤ 511 and fits 3 digits.
- ITER, WIDTH, number of double-dabble iterations; localparam, not overridable.

Ports:
- CLOCK_50  in  1  system clock; every register is clocked on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- out_data  in  WIDTH  binary value from the computer's output register.
- out_load  in  1  single-cycle strobe; out_data is valid in the same cycle.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse in the cycle after HEX/bcd update.
- bcd  out  12  {hundreds, tens, units}, 4 bits each.
- HEX0  out  7  units digit, active-low, bit0 = seg a … bit6 = seg g.
- HEX1  out  7  tens digit, same encoding.
- HEX2  out  7  hundreds digit, same encoding.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE; busy = 0, done = 0, bcd = 12'h000, pending flag cleared.
  - HEX2/HEX1/HEX0 = 7'h40 ("000"). With the optional feature enabled: HEX2 = HEX1 = 7'h7F, HEX0 = 7'h40.
- Segment codes for 0–9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex). Blank = 7'h7F.
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE:
  - On out_load, load the shift register {12'b0, out_data}, clear iteration counter cnt, go to CONVERT, set busy = 1.
- CONVERT (one iteration per cycle):
  - Each BCD nibble ≥ 5 gets +3, then the whole register shifts left by 1. Nibble adds are 4-bit with no carry between nibbles.
  - cnt increments each cycle. When cnt == ITER-1, go to UPDATE.
- UPDATE:
  - Register bcd and HEX0..2 from the converted nibbles. busy = 0 and done = 1 on the following cycle.
  - If pending is set, start that value immediately: back to CONVERT with busy = 1, pending cleared. done still pulses.
  - Otherwise go to IDLE.
- Latency: for a load sampled at edge E, HEX/bcd change at edge E+ITER+1 (E+9 for WIDTH = 8). done is high for exactly one cycle after that edge.
- Loads while busy (CONVERT or UPDATE):
  - Capture out_data into the pending buffer and set pending.
  - A newer load overwrites an unconsumed pending value (last-write-wins). No load is ever lost except superseded ones.
- A load in the same cycle the FSM leaves UPDATE for IDLE is accepted as a new IDLE load; it is not dropped.
- HEX outputs hold their last displayed value throughout a conversion; there is no flicker.
- Reset mid-conversion returns immediately to reset values. The in-flight conversion and the pending value are discarded.

Optional Feature:
- Macro: OUTPUT_DISPLAY_BLANK_EN.
- Defined: leading zeros are blanked.
  - HEX2 = 7'h7F when hundreds == 0.
  - HEX1 = 7'h7F when hundreds == 0 and tens == 0.
  - HEX0 is never blanked.
  - bcd is unaffected.
- Undefined: all three digits are always shown.

Decomposition:
- Package computer_pkg:
  - Segment constants SEG_0..SEG_9 and SEG_BLANK.
  - State enum/localparams for IDLE/CONVERT/UPDATE.
  - BCD_DIGITS = 3.
- One sub-module, seg7_decoder: 4-bit BCD in, 7-bit active-low segments out, purely combinational. Instantiated three times; output registering is done in output_display.

Test Plan:
- Hold rst_n = 0 for 3 cycles, then release → HEX2/1/0 = 40/40/40, bcd = 000, busy = 0. With BLANK_EN → 7F/7F/40.
- out_load with out_data = 8'hFF → busy for 9 cycles; at E+9 bcd = 12'h255 and HEX2/1/0 = 24/12/12; done pulses exactly once.
- out_load 8'd123, then out_load 8'd45 at E+2 and 8'd7 at E+4 → first shows 123 (79/24/30). The 7 follows immediately with no IDLE gap and shows 40/40/78. 45 is never displayed.
- Assert rst_n low at E+4 of a conversion of 8'd200 → outputs return to reset values asynchronously, with no done pulse and no later update.
- With OUTPUT_DISPLAY_BLANK_EN, out_data = 8'd7 → 7F/7F/78; 8'd40 → 7F/19/40; 8'd100 → 79/40/40.
- Back-to-back single loads of 0, 9, 10, 99, 100 spaced 12 cycles apart → bcd = 000, 009, 010, 099, 100 (nibble add-3 boundary checks).
